// File: rtl/lcd_bus_responder_pkg.sv
// Shared types and constants for the HD44780-compatible LCD bus responder.
// Address-counter stepping lives here so every file walks the 2x16 layout identically.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } lcd_state_e;

    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    // Column step within a line; the last column wraps onto the start of the other line.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        r = a;
        if (up) begin
            if (a[3:0] == 4'hF) r = a[6] ? 7'h00 : LINE1_BASE;
            else                r = a + 7'd1;
        end else begin
            if (a[3:0] == 4'h0) r = a[6] ? 7'h0F : (LINE1_BASE | 7'h0F);
            else                r = a - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// LCD bus between the executor (master) and the responder (slave).
interface lcd_bus_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (output lcd_rs, lcd_rw, lcd_en, lcd_data_in,
                    input  lcd_data_out, lcd_data_oe);
    modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_data_in,
                    output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/lcd_bus_responder_en_sync.sv
// Brings the asynchronous LCD strobe into the clk domain and flags its falling edge.
// RS/RW/data pass through matching 2-flop copies so they line up with the edge pulse.
module lcd_en_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data,
    output logic       en_lvl,
    output logic       en_fall,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic [7:0] data_sync
);
    logic       en_s1_r, en_s2_r, en_s3_r;
    logic       rs_s1_r, rs_s2_r, rw_s1_r, rw_s2_r;
    logic [7:0] data_s1_r, data_s2_r;

    // Two-stage synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_s1_r   <= 1'b0;
            en_s2_r   <= 1'b0;
            en_s3_r   <= 1'b0;
            rs_s1_r   <= 1'b0;
            rs_s2_r   <= 1'b0;
            rw_s1_r   <= 1'b0;
            rw_s2_r   <= 1'b0;
            data_s1_r <= 8'h00;
            data_s2_r <= 8'h00;
        end else begin
            en_s1_r   <= en;
            en_s2_r   <= en_s1_r;
            en_s3_r   <= en_s2_r;
            rs_s1_r   <= rs;
            rs_s2_r   <= rs_s1_r;
            rw_s1_r   <= rw;
            rw_s2_r   <= rw_s1_r;
            data_s1_r <= data;
            data_s2_r <= data_s1_r;
        end
    end

    assign en_lvl    = en_s2_r;
    assign en_fall   = en_s3_r & ~en_s2_r;
    assign rs_sync   = rs_s2_r;
    assign rw_sync   = rw_s2_r;
    assign data_sync = data_s2_r;
endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder: decodes bus cycles, holds a 2x16 DDRAM, the address
// counter and display flags, models the busy flag and answers status/data reads.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 37,
    parameter int CLEAR_CYCLES = 64,
    parameter int HOME_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_bus_responder_if.slave   bus,
    output logic                 busy,
    output logic [6:0]           ac,
    output logic                 disp_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 two_line,
    input  logic [4:0]           rd_idx,
    output logic [7:0]           rd_char,
    output logic                 err_overrun,
    output logic                 err_unsup
);
    localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES);
    localparam logic [15:0] HOME_LOAD  = 16'(HOME_CYCLES);
    localparam logic [15:0] CLEAR_TAIL = 16'(CLEAR_CYCLES - 32);

    logic       en_lvl_s, fall_s, rs_s, rw_s;
    logic [7:0] data_s;
    logic [4:0] cur_idx_s;

    lcd_state_e state_r;
    logic [15:0] cnt_r;
    logic [4:0]  clr_idx_r;
    logic [6:0]  ac_r;
    logic        id_r, disp_r, cursor_r, blink_r, two_line_r, busy_r;
    logic        err_overrun_r, err_unsup_r;
    logic [7:0]  ddram_r [0:31];
    logic [7:0]  data_out_r;
    logic        oe_r;

    lcd_en_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.lcd_en),
        .rs        (bus.lcd_rs),
        .rw        (bus.lcd_rw),
        .data      (bus.lcd_data_in),
        .en_lvl    (en_lvl_s),
        .en_fall   (fall_s),
        .rs_sync   (rs_s),
        .rw_sync   (rw_s),
        .data_sync (data_s)
    );

    assign cur_idx_s = {ac_r[6], ac_r[3:0]};

    // Controller FSM: owns DDRAM, address counter, flags and the busy timer
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) ddram_r[i] <= SPACE_CHAR;
            state_r       <= ST_IDLE;
            cnt_r         <= 16'd0;
            clr_idx_r     <= 5'd0;
            ac_r          <= 7'd0;
            id_r          <= 1'b1;
            disp_r        <= 1'b0;
            cursor_r      <= 1'b0;
            blink_r       <= 1'b0;
            two_line_r    <= 1'b0;
            busy_r        <= 1'b0;
            err_overrun_r <= 1'b0;
            err_unsup_r   <= 1'b0;
        end else begin
            // Data reads advance ac even while busy; later assignments below take priority
            if (fall_s && rw_s && rs_s) ac_r <= ac_step(ac_r, id_r);
            if (fall_s && !rw_s && state_r != ST_IDLE) err_overrun_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s && !rw_s && rs_s) begin
                        ddram_r[cur_idx_s] <= data_s;
                        ac_r    <= ac_step(ac_r, id_r);
                        state_r <= ST_BUSY;
                        cnt_r   <= BUSY_LOAD;
                        busy_r  <= 1'b1;
                    end else if (fall_s && !rw_s && data_s != 8'h00) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= BUSY_LOAD;
                        busy_r  <= 1'b1;
                        if ((data_s & OP_DDRAM) != 8'h00) begin
                            ac_r <= {data_s[6], 2'b00, data_s[3:0]};
                        end else if ((data_s & OP_CGRAM) != 8'h00) begin
                            cnt_r <= BUSY_LOAD;
                        end else if ((data_s & OP_FUNC) != 8'h00) begin
                            two_line_r <= data_s[3];
                            if (!data_s[4]) err_unsup_r <= 1'b1;
                        end else if ((data_s & OP_SHIFT) != 8'h00) begin
                            if (data_s[3]) err_unsup_r <= 1'b1;
                            else           ac_r <= ac_step(ac_r, data_s[2]);
                        end else if ((data_s & OP_DISP) != 8'h00) begin
                            disp_r   <= data_s[2];
                            cursor_r <= data_s[1];
                            blink_r  <= data_s[0];
                        end else if ((data_s & OP_ENTRY) != 8'h00) begin
                            id_r <= data_s[1];
                            if (data_s[0]) err_unsup_r <= 1'b1;
                        end else if ((data_s & OP_HOME) != 8'h00) begin
                            ac_r  <= 7'd0;
                            cnt_r <= HOME_LOAD;
                        end else begin
                            state_r   <= ST_CLEAR;
                            clr_idx_r <= 5'd0;
                        end
                    end
                end
                ST_CLEAR: begin
                    ddram_r[clr_idx_r] <= SPACE_CHAR;
                    if (clr_idx_r == 5'd31) begin
                        ac_r <= 7'd0;
                        id_r <= 1'b1;
                        if (CLEAR_TAIL == 16'd0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= CLEAR_TAIL;
                        end
                    end else begin
                        clr_idx_r <= clr_idx_r + 5'd1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r <= 16'd1) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-back register: status or DDRAM at ac while a read strobe is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_r <= 8'h00;
            oe_r       <= 1'b0;
        end else begin
            oe_r <= en_lvl_s & rw_s;
            if (en_lvl_s && rw_s) data_out_r <= rs_s ? ddram_r[cur_idx_s] : {busy_r, ac_r};
            else                  data_out_r <= 8'h00;
        end
    end

    assign bus.lcd_data_out = data_out_r;
    assign bus.lcd_data_oe  = oe_r;
    assign busy        = busy_r;
    assign ac          = ac_r;
    assign disp_on     = disp_r;
    assign cursor_on   = cursor_r;
    assign blink_on    = blink_r;
    assign two_line    = two_line_r;
    assign rd_char     = ddram_r[rd_idx];
    assign err_overrun = err_overrun_r;
    assign err_unsup   = err_unsup_r;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed plus randomized bench for lcd_bus_responder; expectations come from a
// linear-position model of the 2x16 display (position 0..31, ac derived from it).
module tb_lcd_bus_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy, disp_on, cursor_on, blink_on, two_line, err_overrun, err_unsup;
    logic [6:0] ac;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [32];
    int         m_pos;
    bit         m_id;

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.BUSY_CYCLES(37), .CLEAR_CYCLES(64), .HOME_CYCLES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .ac          (ac),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .two_line    (two_line),
        .rd_idx      (rd_idx),
        .rd_char     (rd_char),
        .err_overrun (err_overrun),
        .err_unsup   (err_unsup)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pos_to_ac(input int p);
        return 7'((p / 16) * 64 + (p % 16));
    endfunction

    function automatic int pos_next(input int p, input bit up);
        return up ? (p + 1) % 32 : (p + 31) % 32;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        bus.lcd_rs      = rs;
        bus.lcd_rw      = rw;
        bus.lcd_data_in = d;
        bus.lcd_en      = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_en      = 1'b0;
    endtask

    task automatic write_cycle(input logic rs, input logic [7:0] d);
        strobe(rs, 1'b0, d);
        repeat (4) @(negedge clk);
    endtask

    task automatic read_cycle(input logic rs, output logic [7:0] d, output logic oe);
        bus.lcd_rs = rs;
        bus.lcd_rw = 1'b1;
        bus.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        d  = bus.lcd_data_out;
        oe = bus.lcd_data_oe;
        bus.lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        bus.lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic measure_busy(output int n);
        int w = 0;
        n = 0;
        while (busy !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d);
        write_cycle(rs, d);
        wait_idle();
    endtask

    task automatic model_data_write(input logic [7:0] c);
        m_mem[m_pos] = c;
        m_pos = pos_next(m_pos, m_id);
        do_write(1'b1, c);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            chk($sformatf("%s_mem%0d", tag, i), {24'd0, rd_char}, {24'd0, m_mem[i]});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_pos = 0;
        m_id  = 1'b1;
    endtask

    initial begin
        int         n;
        logic [7:0] rd;
        logic       oe;
        int         op, line, col;
        logic [7:0] c;

        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_en = 1'b0; bus.lcd_data_in = 8'h00;
        rd_idx = 5'd0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ac", {25'd0, ac}, 32'd0);
        chk("rst_flags", {28'd0, disp_on, cursor_on, blink_on, two_line}, 32'd0);
        chk("rst_errs", {30'd0, err_overrun, err_unsup}, 32'd0);
        chk("rst_dout", {23'd0, bus.lcd_data_oe, bus.lcd_data_out}, 32'd0);
        check_mem("rst");
        rst = 1'b1;
        @(negedge clk);

        // display control 0x0F: busy length and flags
        strobe(1'b0, 1'b0, 8'h0F);
        measure_busy(n);
        chk("busy_len_37", n, 37);
        chk("disp_flags", {29'd0, disp_on, cursor_on, blink_on}, 32'd7);
        do_write(1'b0, 8'h0C);
        chk("disp_0c", {29'd0, disp_on, cursor_on, blink_on}, 32'd4);

        // line wrap on data write
        do_write(1'b0, 8'h8F);
        m_pos = 15;
        model_data_write(8'h41);
        model_data_write(8'h42);
        rd_idx = 5'd15; #1; chk("entry15", {24'd0, rd_char}, 32'h41);
        rd_idx = 5'd16; #1; chk("entry16", {24'd0, rd_char}, 32'h42);
        chk("ac_after_ab", {25'd0, ac}, 32'h41);

        // write while busy is dropped and flagged
        m_mem[m_pos] = 8'h43;
        m_pos = pos_next(m_pos, m_id);
        write_cycle(1'b1, 8'h43);
        write_cycle(1'b1, 8'h44);
        wait_idle();
        chk("overrun_flag", {31'd0, err_overrun}, 32'd1);
        chk("overrun_ac", {25'd0, ac}, {25'd0, pos_to_ac(m_pos)});
        check_mem("overrun");

        // randomized writes, address sets, entry modes and data reads
        for (int k = 0; k < 28; k++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                c = 8'($urandom_range(33, 126));
                model_data_write(c);
            end else if (op == 1) begin
                line = $urandom_range(0, 1);
                col  = $urandom_range(0, 15);
                m_pos = line * 16 + col;
                do_write(1'b0, 8'h80 | 8'(line * 64) | 8'(col));
            end else if (op == 2) begin
                m_id = 1'($urandom_range(0, 1));
                do_write(1'b0, 8'h04 | {6'd0, m_id, 1'b0});
            end else begin
                read_cycle(1'b1, rd, oe);
                chk($sformatf("rand_read%0d", k), {23'd0, oe, rd}, {23'd1, m_mem[m_pos]});
                m_pos = pos_next(m_pos, m_id);
            end
            chk($sformatf("rand_ac%0d", k), {25'd0, ac}, {25'd0, pos_to_ac(m_pos)});
        end
        check_mem("rand");

        // clear display: busy length, contents, ac, status reads
        strobe(1'b0, 1'b0, 8'h01);
        measure_busy(n);
        model_reset();
        chk("clear_len_64", n, 64);
        check_mem("clear");
        chk("clear_ac", {25'd0, ac}, 32'd0);
        read_cycle(1'b0, rd, oe);
        chk("status_idle", {23'd0, oe, rd}, 32'h100);
        write_cycle(1'b0, 8'h01);
        repeat (30) @(negedge clk);
        read_cycle(1'b0, rd, oe);
        chk("status_busy", {23'd0, oe, rd}, 32'h180);
        wait_idle();

        // decrement mode and both wrap directions
        m_id = 1'b0;
        do_write(1'b0, 8'h04);
        do_write(1'b0, 8'hC0);
        m_pos = 16;
        model_data_write(8'h5A);
        chk("entry16_z", {24'd0, m_mem[16]}, 32'h5A);
        chk("ac_dec", {25'd0, ac}, 32'h0F);
        do_write(1'b0, 8'h80);
        m_pos = 0;
        model_data_write(8'h59);
        chk("ac_dec_wrap", {25'd0, ac}, 32'h4F);
        m_id = 1'b1;
        do_write(1'b0, 8'h06);
        do_write(1'b0, 8'hCF);
        m_pos = 31;
        model_data_write(8'h57);
        chk("ac_inc_wrap", {25'd0, ac}, 32'h00);
        do_write(1'b0, 8'hC0);
        m_pos = 16;
        read_cycle(1'b1, rd, oe);
        chk("read_z", {24'd0, rd}, {24'd0, m_mem[16]});
        m_pos = pos_next(m_pos, m_id);
        chk("read_adv", {25'd0, ac}, {25'd0, pos_to_ac(m_pos)});
        check_mem("dec");

        // cursor shift right, return home busy length
        do_write(1'b0, 8'h14);
        m_pos = pos_next(m_pos, 1'b1);
        chk("shift_ac", {25'd0, ac}, {25'd0, pos_to_ac(m_pos)});
        strobe(1'b0, 1'b0, 8'h02);
        measure_busy(n);
        chk("home_len_64", n, 64);
        chk("home_ac", {25'd0, ac}, 32'd0);

        // function set with 4-bit mode
        chk("unsup_pre", {31'd0, err_unsup}, 32'd0);
        do_write(1'b0, 8'h28);
        chk("unsup_28", {31'd0, err_unsup}, 32'd1);
        chk("two_line", {31'd0, two_line}, 32'd1);

        // reset in the middle of a clear
        write_cycle(1'b0, 8'h01);
        repeat (2) @(negedge clk);
        chk("mid_clear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ac", {25'd0, ac}, 32'd0);
        chk("mrst_flags", {28'd0, disp_on, cursor_on, blink_on, two_line}, 32'd0);
        chk("mrst_errs", {30'd0, err_overrun, err_unsup}, 32'd0);
        chk("mrst_dout", {23'd0, bus.lcd_data_oe, bus.lcd_data_out}, 32'd0);
        check_mem("mrst");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
